// File: rtl/emergency_preempt_if.sv
// Lane-sensor / light-mux side bundle of the emergency preemption controller.
// The slave modport is the controller; the master modport is the sensor/mux side.
interface emergency_preempt_if #(
   parameter int unsigned NUM_APPROACH       = 4,
   parameter int unsigned LANES_PER_APPROACH = 2,
   parameter int unsigned TIME_W             = 7
);
   localparam int unsigned NumLanes = NUM_APPROACH * LANES_PER_APPROACH;

   logic [NumLanes-1:0]     emergency_lane;
   logic [NumLanes-1:0]     emergency_light_output;
   logic [NUM_APPROACH-1:0] grant;
   logic                    all_red;
   logic                    active;
   logic                    load_cmd;
   logic [TIME_W-1:0]       load_time;

   modport master (
      output emergency_lane,
      input  emergency_light_output, grant, all_red, active, load_cmd, load_time
   );

   modport slave (
      input  emergency_lane,
      output emergency_light_output, grant, all_red, active, load_cmd, load_time
   );
endinterface

// File: rtl/emergency_preempt.sv
// Emergency-vehicle preemption: round-robin approach arbitration, all-red clearance,
// bounded grant hold, and a one-cycle hand-back load command to the normal sequencer.
module emergency_preempt #(
   parameter int unsigned NUM_APPROACH       = 4,
   parameter int unsigned LANES_PER_APPROACH = 2,
   parameter int unsigned CLEAR_TIME         = 3,
   parameter int unsigned MIN_HOLD           = 10,
   parameter int unsigned MAX_HOLD           = 40,
   parameter int unsigned RESUME_TIME        = 3,
   parameter int unsigned TIME_W             = 7
) (
   input logic               clk,
   input logic               rst,
   emergency_preempt_if.slave bus
);
   localparam int unsigned NumLanes = NUM_APPROACH * LANES_PER_APPROACH;
   localparam int unsigned SW = (NUM_APPROACH > 1) ? $clog2(NUM_APPROACH) : 1;
   localparam int unsigned CW = (CLEAR_TIME > 1) ? $clog2(CLEAR_TIME) : 1;
   localparam int unsigned HW = ($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1;

   localparam logic [CW-1:0]     ClearInit  = CW'(CLEAR_TIME - 1);
   localparam logic [HW-1:0]     MinHold    = HW'(MIN_HOLD);
   localparam logic [HW-1:0]     MaxHold    = HW'(MAX_HOLD);
   localparam logic [SW-1:0]     LastAppr   = SW'(NUM_APPROACH - 1);
   localparam logic [TIME_W-1:0] ResumeTime = TIME_W'(RESUME_TIME);

   typedef enum logic [1:0] {StIdle, StClear, StGrant} state_e;

   state_e                  state_q, state_d;
   logic [SW-1:0]           sel_q, sel_d;
   logic [SW-1:0]           ptr_q, ptr_d;
   logic [CW-1:0]           clr_q, clr_d;
   logic [HW-1:0]           hold_q, hold_d;
   logic [NUM_APPROACH-1:0] grant_q, grant_d;
   logic [NumLanes-1:0]     lights_q, lights_d;
   logic                    all_red_q, all_red_d;
   logic                    active_q, active_d;
   logic                    load_q, load_d;
   logic [TIME_W-1:0]       load_time_q, load_time_d;

   logic [NUM_APPROACH-1:0] req;
   logic [NUM_APPROACH-1:0] others;
   logic [HW-1:0]           hold_inc;
   logic [SW-1:0]           ptr_after;

   // First requesting approach at or after base, wrapping modulo NUM_APPROACH.
   function automatic logic [SW-1:0] rr_pick(input logic [NUM_APPROACH-1:0] r,
                                             input logic [SW-1:0] base);
      logic [SW-1:0] res;
      logic [SW-1:0] idx_s;
      logic          hit;
      int unsigned   idx;
      res = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < NUM_APPROACH; i++) begin
         idx   = (32'(base) + i) % NUM_APPROACH;
         idx_s = SW'(idx);
         if (!hit && r[idx_s]) begin
            hit = 1'b1;
            res = idx_s;
         end
      end
      return res;
   endfunction

   for (genvar a = 0; a < NUM_APPROACH; a++) begin : g_appr
      assign req[a] = |bus.emergency_lane[a*LANES_PER_APPROACH +: LANES_PER_APPROACH];
      assign lights_d[a*LANES_PER_APPROACH +: LANES_PER_APPROACH] =
         {LANES_PER_APPROACH{grant_d[a]}};
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      clr_d     = clr_q;
      hold_d    = hold_q;
      load_d    = 1'b0;
      others    = req & ~(NUM_APPROACH'(1) << sel_q);
      hold_inc  = (hold_q >= MaxHold) ? hold_q : hold_q + HW'(1);
      ptr_after = (sel_q == LastAppr) ? '0 : sel_q + SW'(1);

      unique case (state_q)
         StIdle: begin
            if (|req) begin
               sel_d   = rr_pick(req, ptr_q);
               clr_d   = ClearInit;
               state_d = StClear;
            end
         end
         StClear: begin
            if (clr_q == '0) begin
               hold_d  = '0;
               state_d = StGrant;
            end else begin
               clr_d = clr_q - CW'(1);
            end
         end
         StGrant: begin
            hold_d = hold_inc;
            // hold_inc counts the current cycle, so a grant lasts at least MIN_HOLD cycles.
            if (hold_inc >= MinHold && (!req[sel_q] || (hold_inc >= MaxHold && |others))) begin
               ptr_d  = ptr_after;
               hold_d = '0;
               if (|others) begin
                  sel_d   = rr_pick(others, ptr_after);
                  clr_d   = ClearInit;
                  state_d = StClear;
               end else begin
                  load_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      all_red_d   = (state_d == StClear);
      active_d    = (state_d != StIdle);
      grant_d     = (state_d == StGrant) ? (NUM_APPROACH'(1) << sel_d) : '0;
      load_time_d = load_d ? ResumeTime : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         ptr_q       <= '0;
         clr_q       <= '0;
         hold_q      <= '0;
         grant_q     <= '0;
         lights_q    <= '0;
         all_red_q   <= 1'b0;
         active_q    <= 1'b0;
         load_q      <= 1'b0;
         load_time_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         clr_q       <= clr_d;
         hold_q      <= hold_d;
         grant_q     <= grant_d;
         lights_q    <= lights_d;
         all_red_q   <= all_red_d;
         active_q    <= active_d;
         load_q      <= load_d;
         load_time_q <= load_time_d;
      end
   end

   assign bus.grant                  = grant_q;
   assign bus.emergency_light_output = lights_q;
   assign bus.all_red                = all_red_q;
   assign bus.active                 = active_q;
   assign bus.load_cmd               = load_q;
   assign bus.load_time              = load_time_q;
endmodule

// File: tb/tb_emergency_preempt.sv
// Scoreboard bench for emergency_preempt: per-cycle expected outputs are derived from
// scenario timelines, queued when stimulus is driven and compared one cycle later.
module tb_emergency_preempt;
   localparam int unsigned NA  = 4;
   localparam int unsigned LPA = 2;
   localparam int unsigned TW  = 7;

   typedef struct packed {
      logic [3:0] g;
      logic [7:0] l;
      logic       ar;
      logic       act;
      logic       ld;
      logic [6:0] lt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   emergency_preempt_if #(.NUM_APPROACH(NA), .LANES_PER_APPROACH(LPA), .TIME_W(TW)) bus ();

   emergency_preempt #(
      .NUM_APPROACH(NA), .LANES_PER_APPROACH(LPA), .CLEAR_TIME(3), .MIN_HOLD(10),
      .MAX_HOLD(40), .RESUME_TIME(3), .TIME_W(TW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // kind: 0 idle, 1 idle with hand-back, 2 clearance, 3 grant to approach a
   function automatic exp_t mk(input int kind, input int a);
      exp_t e;
      e = '0;
      case (kind)
         1: begin e.ld = 1'b1; e.lt = 7'd3; end
         2: begin e.ar = 1'b1; e.act = 1'b1; end
         3: begin e.act = 1'b1; e.g = 4'(1 << a); e.l = 8'(3 << (2 * a)); end
         default: ;
      endcase
      return e;
   endfunction

   function automatic logic [7:0] lanes_of(input int s, input int c);
      case (s)
         0: return (c <= 19) ? 8'h20 : 8'h00;
         1: return (c == 0) ? 8'h01 : 8'h00;
         2: return ((c <= 1) ? 8'h42 : 8'h00) | ((c >= 8 && c <= 13) ? 8'h40 : 8'h00);
         3: return 8'h14;
         default: return (c == 0) ? 8'h01 : ((c >= 15) ? 8'h09 : 8'h00);
      endcase
   endfunction

   function automatic bit in(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   function automatic exp_t exp_of(input int s, input int c);
      case (s)
         0: begin
            if (in(c, 1, 3))  return mk(2, 0);
            if (in(c, 4, 20)) return mk(3, 2);
            if (c == 21)      return mk(1, 0);
         end
         1: begin
            if (in(c, 1, 3))  return mk(2, 0);
            if (in(c, 4, 13)) return mk(3, 0);
            if (c == 14)      return mk(1, 0);
         end
         2: begin
            if (in(c, 1, 3))   return mk(2, 0);
            if (in(c, 4, 13))  return mk(3, 0);
            if (in(c, 14, 16)) return mk(2, 0);
            if (in(c, 17, 26)) return mk(3, 3);
            if (c == 27)       return mk(1, 0);
         end
         3: begin
            if (in(c, 1, 3))    return mk(2, 0);
            if (in(c, 4, 43))   return mk(3, 1);
            if (in(c, 44, 46))  return mk(2, 0);
            if (in(c, 47, 86))  return mk(3, 2);
            if (in(c, 87, 89))  return mk(2, 0);
            if (in(c, 90, 129)) return mk(3, 1);
         end
         default: begin
            if (in(c, 1, 3))   return mk(2, 0);
            if (in(c, 4, 13))  return mk(3, 0);
            if (c == 14)       return mk(1, 0);
            if (in(c, 16, 18)) return mk(2, 0);
            if (in(c, 19, 22)) return mk(3, 1);
            if (in(c, 24, 26)) return mk(2, 0);
            if (c >= 27)       return mk(3, 0);
         end
      endcase
      return mk(0, 0);
   endfunction

   task automatic check_zero(input string tag);
      check_eq({tag, " grant"},   32'(bus.grant), 32'd0);
      check_eq({tag, " lights"},  32'(bus.emergency_light_output), 32'd0);
      check_eq({tag, " all_red"}, 32'(bus.all_red), 32'd0);
      check_eq({tag, " active"},  32'(bus.active), 32'd0);
      check_eq({tag, " load"},    32'(bus.load_cmd), 32'd0);
      check_eq({tag, " ltime"},   32'(bus.load_time), 32'd0);
   endtask

   task automatic compare_out(input int s, input int c);
      exp_t  e;
      string t;
      e = sb.pop_front();
      t = $sformatf("s%0d c%0d", s, c);
      check_eq({t, " grant"},   32'(bus.grant), 32'(e.g));
      check_eq({t, " lights"},  32'(bus.emergency_light_output), 32'(e.l));
      check_eq({t, " all_red"}, 32'(bus.all_red), 32'(e.ar));
      check_eq({t, " active"},  32'(bus.active), 32'(e.act));
      check_eq({t, " load"},    32'(bus.load_cmd), 32'(e.ld));
      check_eq({t, " ltime"},   32'(bus.load_time), 32'(e.lt));
   endtask

   task automatic run_scn(input int s, input int n);
      rst = 1'b1;
      bus.emergency_lane = '0;
      sb.delete();
      repeat (2) @(negedge clk);
      check_zero($sformatf("s%0d in_reset", s));
      sb.push_back(exp_of(s, 0));
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (c == 0) rst = 1'b0;
         compare_out(s, c);
         bus.emergency_lane = lanes_of(s, c);
         sb.push_back(exp_of(s, c + 1));
         // Asynchronous reset mid-grant must clear outputs without waiting for a clock.
         if (s == 4 && c == 22) begin
            rst = 1'b1;
            #1;
            check_zero($sformatf("s%0d async_rst", s));
         end
         if (s == 4 && c == 23) rst = 1'b0;
      end
   endtask

   initial begin
      run_scn(0, 26);
      run_scn(1, 20);
      run_scn(2, 32);
      run_scn(3, 110);
      run_scn(4, 40);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
